serial_digit_adder: RTL

//   Multi-cycle, parametrised add/subtract unit: adds two WIDTH-bit operands

---
 rtl/serial_digit_adder.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_digit_adder.sv
// Multi-cycle add/subtract unit: processes DIGIT bits per clock through a
// DIGIT-bit ripple slice with a registered carry, valid/ready on both sides.
module serial_digit_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic [WIDTH-1:0] a_shift, b_shift, sum_shift;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg, cout_reg, ovf_reg;
  logic [DIGIT:0]   slice;
  logic             msb_cin;
  logic             last_digit;

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign last_digit = (cnt_reg == CW'(NDIG - 1));

  // Operands are shifted down so the slice always works on the low digit;
  // result digits enter at the top and land in place after NDIG shifts.
  assign slice   = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_reg};
  assign msb_cin = a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ slice[DIGIT-1];

  generate
    if (NDIG == 1) begin : g_single
      assign a_shift   = '0;
      assign b_shift   = '0;
      assign sum_shift = slice[DIGIT-1:0];
    end else begin : g_multi
      assign a_shift   = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
      assign b_shift   = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
      assign sum_shift = {slice[DIGIT-1:0], sum_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as a + ~b + ~borrow_in.
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub}};
            carry_reg <= cin ^ sub;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_shift;
          b_reg     <= b_shift;
          sum_reg   <= sum_shift;
          carry_reg <= slice[DIGIT];
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_digit) begin
            cout_reg <= slice[DIGIT];
            ovf_reg  <= msb_cin ^ slice[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
